// File: rtl/bolt_engine.sv
// bolt_engine: per-slot bolt flight, border clamping and registered pixel drawing requests
module bolt_engine #(
   parameter int           BOLT_MAX = 4,
   parameter int           SPEED    = 4,
   parameter bit           DIR_DOWN = 1'b1,
   parameter int           BOLT_W   = 3,
   parameter int           BOLT_H   = 8,
   parameter int           T_LIM    = 5,
   parameter int           B_LIM    = 465,
   parameter logic [7:0]   BOLT_RGB = 8'hFC
)(
   input  logic                     clk,
   input  logic                     resetN,
   input  logic                     srtFrm,
   input  logic [10:0]              pixelX,
   input  logic [10:0]              pixelY,
   input  logic [BOLT_MAX-1:0]      exs,
   input  logic [10:0]              spnX,
   input  logic [10:0]              spnY,
   output logic [BOLT_MAX-1:0]      req,
   output logic                     anyReq,
   output logic [7:0]               rgb,
   output logic [BOLT_MAX*11-1:0]   posY
);
   typedef enum logic [1:0] {IDLE, FLY, PARK} state_t;
   state_t              r_st  [BOLT_MAX];
   state_t              w_nst [BOLT_MAX];
   logic [10:0]         r_x   [BOLT_MAX];
   logic [10:0]         r_y   [BOLT_MAX];
   logic [10:0]         w_nx  [BOLT_MAX];
   logic [10:0]         w_ny  [BOLT_MAX];
   logic [11:0]         w_dn  [BOLT_MAX];
   logic signed [11:0]  w_up  [BOLT_MAX];
   logic [BOLT_MAX-1:0] r_exsQ;
   logic [BOLT_MAX-1:0] w_rise;
   logic [BOLT_MAX-1:0] w_req;
   logic                w_lo;
   logic                w_hi;
   logic [10:0]         w_spy;
   assign w_rise = exs & ~r_exsQ;
   assign w_lo   = spnY < 11'(T_LIM);
   assign w_hi   = spnY > 11'(B_LIM);
   assign w_spy  = w_lo ? 11'(T_LIM) : w_hi ? 11'(B_LIM) : spnY;
   // next state and position per slot; a dropped exs beats a frame tick, out-of-range spawns park at once
   always_comb begin
      for (int i = 0; i < BOLT_MAX; i++) begin
         w_nst[i] = r_st[i];
         w_nx[i]  = r_x[i];
         w_ny[i]  = r_y[i];
         w_dn[i]  = {1'b0, r_y[i]} + 12'(SPEED);
         w_up[i]  = $signed({1'b0, r_y[i]}) - $signed(12'(SPEED));
         if (r_st[i] == IDLE) begin
            if (w_rise[i]) begin
               w_nx[i]  = spnX;
               w_ny[i]  = w_spy;
               w_nst[i] = (w_lo || w_hi) ? PARK : FLY;
            end
         end else if (!exs[i]) begin
            w_nst[i] = IDLE;
         end else if (r_st[i] == FLY && srtFrm) begin
            if (DIR_DOWN) begin
               w_ny[i]  = (w_dn[i] >= 12'(B_LIM)) ? 11'(B_LIM) : w_dn[i][10:0];
               w_nst[i] = (w_dn[i] >= 12'(B_LIM)) ? PARK : FLY;
            end else begin
               w_ny[i]  = (w_up[i] <= $signed(12'(T_LIM))) ? 11'(T_LIM) : w_up[i][10:0];
               w_nst[i] = (w_up[i] <= $signed(12'(T_LIM))) ? PARK : FLY;
            end
         end
      end
   end
   // pixel hit test in 12 bits so a bolt near column 2047 cannot wrap onto low columns; req drops as soon as exs does
   always_comb begin
      w_req = '0;
      posY  = '0;
      for (int i = 0; i < BOLT_MAX; i++) begin
         w_req[i] = (r_st[i] != IDLE) && exs[i] &&
                    ({1'b0, pixelX} >= {1'b0, r_x[i]}) && ({1'b0, pixelX} < {1'b0, r_x[i]} + 12'(BOLT_W)) &&
                    ({1'b0, pixelY} >= {1'b0, r_y[i]}) && ({1'b0, pixelY} < {1'b0, r_y[i]} + 12'(BOLT_H));
         posY[i*11 +: 11] = r_y[i];
      end
   end
   // slot state, positions, exs history and registered drawing outputs
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_exsQ <= '0;
         req    <= '0;
         anyReq <= 1'b0;
         rgb    <= 8'h00;
         for (int i = 0; i < BOLT_MAX; i++) begin
            r_st[i] <= IDLE;
            r_x[i]  <= '0;
            r_y[i]  <= '0;
         end
      end else begin
         r_exsQ <= exs;
         req    <= w_req;
         anyReq <= |w_req;
         rgb    <= (|w_req) ? BOLT_RGB : 8'h00;
         for (int i = 0; i < BOLT_MAX; i++) begin
            r_st[i] <= w_nst[i];
            r_x[i]  <= w_nx[i];
            r_y[i]  <= w_ny[i];
         end
      end
   end
endmodule

// File: tb/tb_bolt_engine.sv
// tb_bolt_engine: directed checks of bolt_engine in falling and rising configurations
module tb_bolt_engine;
   logic        clk = 1'b0;
   logic        resetN, srtFrm;
   logic [10:0] pixelX, pixelY, spnX, spnY;
   logic [3:0]  exs_d, exs_u, req_d, req_u;
   logic        any_d, any_u;
   logic [7:0]  rgb_d, rgb_u;
   logic [43:0] posy_d, posy_u;
   int          n_chk = 0;
   int          n_err = 0;
   always #5 clk = ~clk;
   bolt_engine #(.DIR_DOWN(1'b1)) u_dn (
      .clk(clk), .resetN(resetN), .srtFrm(srtFrm), .pixelX(pixelX), .pixelY(pixelY),
      .exs(exs_d), .spnX(spnX), .spnY(spnY), .req(req_d), .anyReq(any_d), .rgb(rgb_d), .posY(posy_d));
   bolt_engine #(.DIR_DOWN(1'b0)) u_up (
      .clk(clk), .resetN(resetN), .srtFrm(srtFrm), .pixelX(pixelX), .pixelY(pixelY),
      .exs(exs_u), .spnX(spnX), .spnY(spnY), .req(req_u), .anyReq(any_u), .rgb(rgb_u), .posY(posy_u));
   task automatic check(input string tag, input logic [43:0] got, input logic [43:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic frame();
      srtFrm = 1'b1;
      step(1);
      srtFrm = 1'b0;
      step(1);
   endtask
   task automatic pix(input int x, input int y);
      pixelX = 11'(x);
      pixelY = 11'(y);
      step(1);
   endtask
   initial begin
      resetN = 1'b0; srtFrm = 1'b0; pixelX = '0; pixelY = '0;
      spnX = '0; spnY = '0; exs_d = '0; exs_u = '0;
      step(2);
      check("rst_posy", posy_d, 44'd0);
      check("rst_req", {any_d, req_d}, 5'd0);
      check("rst_rgb", rgb_d, 8'h00);
      resetN = 1'b1;
      step(1);
      check("post_rst_idle", {req_d, req_u}, 8'd0);
      exs_d = 4'b0001; spnX = 11'd100; spnY = 11'd40;
      step(1);
      check("spawn_y", posy_d[10:0], 11'd40);
      frame(); frame(); frame();
      check("move3_y", posy_d[10:0], 11'd52);
      pixelX = 11'd101; pixelY = 11'd55;
      #1 check("req_latency0", req_d, 4'b0000);
      step(1);
      check("req_hit", req_d, 4'b0001);
      check("hit_any_rgb", {any_d, rgb_d}, {1'b1, 8'hFC});
      pix(101, 60);
      check("req_y_excl", req_d, 4'b0000);
      pix(103, 55);
      check("req_x_excl", req_d, 4'b0000);
      pix(102, 59);
      check("req_corner", req_d, 4'b0001);
      exs_d = 4'b0000;
      step(1);
      check("req_drop", req_d, 4'b0000);
      exs_d = 4'b0001; spnY = 11'd462;
      step(1);
      check("bot_spawn", posy_d[10:0], 11'd462);
      frame();
      check("bot_clamp", posy_d[10:0], 11'd465);
      frame();
      check("bot_hold", posy_d[10:0], 11'd465);
      pix(100, 465);
      check("park_req", req_d, 4'b0001);
      exs_d = 4'b0000;
      step(1);
      check("park_drop", req_d, 4'b0000);
      exs_u = 4'b0001; spnX = 11'd50; spnY = 11'd7;
      step(1);
      check("up_spawn", posy_u[10:0], 11'd7);
      frame();
      check("top_clamp", posy_u[10:0], 11'd5);
      pix(50, 5);
      check("top_req", req_u, 4'b0001);
      pix(50, 4);
      check("top_above", req_u, 4'b0000);
      exs_u = 4'b0011; spnX = 11'd60; spnY = 11'd2;
      step(1);
      check("lo_spawn_clamp", posy_u[21:11], 11'd5);
      frame();
      check("lo_spawn_park", {posy_u[21:11], posy_u[10:0]}, {11'd5, 11'd5});
      pix(61, 12);
      check("lo_spawn_req", req_u, 4'b0010);
      exs_d = 4'b0010; spnX = 11'd300; spnY = 11'd200; srtFrm = 1'b1;
      step(1);
      srtFrm = 1'b0;
      check("rise_frm", posy_d[21:11], 11'd200);
      frame();
      check("rise_then_move", posy_d[21:11], 11'd204);
      exs_d = 4'b0000; srtFrm = 1'b1;
      step(1);
      srtFrm = 1'b0;
      check("fall_frm", posy_d[21:11], 11'd204);
      frame();
      check("idle_no_move", posy_d[21:11], 11'd204);
      exs_d = 4'b0101; spnX = 11'd200; spnY = 11'd100;
      step(1);
      check("multi_y", {posy_d[32:22], posy_d[10:0]}, {11'd100, 11'd100});
      pix(201, 101);
      check("multi_req", req_d, 4'b0101);
      check("multi_any_rgb", {any_d, rgb_d}, {1'b1, 8'hFC});
      exs_d = 4'b1101; spnX = 11'd2046;
      step(1);
      check("edge_spawn_y", posy_d[43:33], 11'd100);
      pix(0, 101);
      check("no_wrap", req_d, 4'b0000);
      pix(2047, 101);
      check("edge_hit", req_d, 4'b1000);
      pix(201, 101);
      check("pre_rst_req", req_d, 4'b0101);
      resetN = 1'b0;
      #1;
      check("async_rst_req", {any_d, req_d}, 5'd0);
      check("async_rst_rgb", rgb_d, 8'h00);
      check("async_rst_posy", posy_d, 44'd0);
      step(1);
      resetN = 1'b1; spnX = 11'd200; spnY = 11'd100;
      #1 check("rel_posy", posy_d, 44'd0);
      step(1);
      check("respawn_y", {posy_d[43:33], posy_d[10:0]}, {11'd100, 11'd100});
      check("respawn_req0", req_d, 4'b0000);
      step(1);
      check("respawn_req", req_d, 4'b1101);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/bolt_engine.md
BOLT_ENGINE -- requirements
Module: bolt_engine

Interface
REQ-001 The block SHALL have these parameters:
- BOLT_MAX, 4: number of bolt slots.
- SPEED, 4: pixels moved per frame.
- DIR_DOWN, 1: 1 means bolts move down (invader bolts); 0 means up (player bolts).
- BOLT_W, 3: bolt width in pixels.
- BOLT_H, 8: bolt height in pixels.
- T_LIM, 5: top border row.
- B_LIM, 465: bottom border row.
- BOLT_RGB, 8'hFC: bolt colour.
REQ-002 The block SHALL have one clock and an asynchronous active-low reset; the ports SHALL be:
- clk  in  1  system clock, all state on rising edge.
- resetN  in  1  asynchronous active-low reset.
- srtFrm  in  1  one-cycle start-of-frame pulse.
- pixelX  in  11  current scan column.
- pixelY  in  11  current scan row.
- exs  in  BOLT_MAX  per-slot "bolt exists" command from the game controller.
- spnX  in  11  spawn column, valid in the cycle exs[i] rises.
- spnY  in  11  spawn row, valid in the cycle exs[i] rises.
- req  out  BOLT_MAX  per-slot drawing request.
- anyReq  out  1  OR of req.
- rgb  out  8  BOLT_RGB when anyReq=1, else 8'h00.
- posY  out  BOLT_MAX*11  per-slot current top row, for debug and verification.

Function
REQ-003 Each slot SHALL run an independent FSM with states IDLE, FLY and PARK.
REQ-004 The block SHALL register exs every cycle as exsQ; a rise is exs[i]=1 and exsQ[i]=0.
REQ-005 IDLE -> FLY on a rise of exs[i]: x[i] and y[i] SHALL latch spnX/spnY in that cycle.
REQ-006 FLY, srtFrm=1, DIR_DOWN=1: y <= y+SPEED; if y+SPEED >= B_LIM, then y <= B_LIM and the slot SHALL go to PARK.
REQ-007 FLY, srtFrm=1, DIR_DOWN=0: y <= y-SPEED; if y-SPEED <= T_LIM, then y <= T_LIM and the slot SHALL go to PARK.
REQ-008 The y arithmetic SHALL use 12-bit signed intermediates so that no 11-bit wrap-around occurs; y SHALL never leave [T_LIM, B_LIM] once in FLY or PARK.
REQ-009 A spawn row outside [T_LIM, B_LIM] SHALL be clamped to the nearer limit at latch, and that slot SHALL enter PARK directly.
REQ-010 PARK SHALL hold position and keep drawing until exs[i]=0; the controller removes a bolt when it sees a request on the border row.
REQ-011 FLY or PARK -> IDLE in any cycle with exs[i]=0; this SHALL take priority over a simultaneous srtFrm.
REQ-012 A rise of exs[i] coinciding with srtFrm SHALL latch the spawn position with no movement in that frame.
REQ-013 Several slots rising in the same cycle SHALL all latch the same spnX/spnY.
REQ-014 The block SHALL ignore exs[i]=1 while the slot is already in FLY or PARK, with no re-latch.
REQ-015 req[i] SHALL be registered as: slot not IDLE, x[i] <= pixelX < x[i]+BOLT_W, and y[i] <= pixelY < y[i]+BOLT_H; latency SHALL be exactly 1 clock from pixelX/pixelY.
REQ-016 req[i] SHALL deassert in the clock after the slot enters IDLE.
REQ-017 The x+BOLT_W and y+BOLT_H comparisons SHALL use 12-bit widths, so a bolt at column 2046 produces no spurious match at low columns.
REQ-018 anyReq and rgb SHALL be registered alongside req with the same latency.
REQ-019 posY SHALL reflect the y registers directly, with no extra latency.

Reset
REQ-020 resetN=0 SHALL asynchronously force, independent of clk:
- all slots to IDLE;
- x, y and exsQ to 0;
- req, anyReq and rgb to 0;
- posY to 0.
REQ-021 Reset asserted mid-flight SHALL discard the bolt.
REQ-022 After reset release, a slot whose exs is already 1 SHALL count that as a rise on the first clock (exsQ=0) and spawn.
REQ-023 No output SHALL change in the first clock edge with resetN=1, except by REQ-022.

Verification
REQ-024 The bench SHALL cover at least these directed scenarios:
- Spawn/move: DIR_DOWN=1; exs[0] rises with spnX=100, spnY=40; then 3 srtFrm pulses -> posY[0]=52; req[0]=1 exactly one clock after pixel (101,55).
- Bottom clamp: spnY=462, then 1 srtFrm -> posY=465, state PARK; further srtFrm leave 465; exs[0] drops -> req[0]=0 on the next clock.
- Top clamp / no wrap: DIR_DOWN=0, spnY=7, then 1 srtFrm -> posY=5 (not 2047); req observed at pixelY=5.
- Simultaneous events: exs rise with srtFrm in the same cycle -> posY equals spnY. exs fall with srtFrm in the same cycle -> IDLE, posY unchanged.
- Multi-slot: exs=4'b0101 rises at once with spnX=200, spnY=100 -> slots 0 and 2 both at (200,100); req=4'b0101 at pixel (201,101); anyReq=1, rgb=8'hFC.
- Reset mid-flight: resetN pulse low with 2 slots flying -> all outputs 0 immediately; with exs held at 1 through release -> respawn on the first clock.
